// File: rtl/led_pattern_gen_if.sv
// Control and display bundle between the board switches/keys and the LED pattern generator.
// The master drives mode/period/pause/step. The slave returns the registered leds and adv.
interface led_pattern_gen_if #(
   parameter int WIDTH = 18,
   parameter int CNT_W = 24
);
   logic [1:0]       mode;
   logic [CNT_W-1:0] period;
   logic             pause;
   logic             step;
   logic [WIDTH-1:0] leds;
   logic             adv;

   modport master (output mode, period, pause, step, input leds, adv);
   modport slave  (input mode, period, pause, step, output leds, adv);
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator with rotate-left, rotate-right, bounce and bar modes. Each step occurs every period+1 clocks, and pause/step give manual control.
// leds and adv change one clock after the advance event. The generator never applies backpressure, and a mode change reseeds all state.
module led_pattern_gen #(
   parameter int WIDTH = 18,
   parameter int CNT_W = 24
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   led_pattern_gen_if.slave bus
);

   typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;
   typedef enum logic {BAR_FILL, BAR_DRAIN} bar_t;

   logic [WIDTH-1:0] leds_q, leds_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       mode_q;
   dir_t             dir_q, dir_d;
   bar_t             bar_q, bar_d;
   logic             adv_q, adv_d;
   logic             tick, ev;
   logic [WIDTH-1:0] shifted;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         leds_q  <= WIDTH'(1);
         count_q <= '0;
         dir_q   <= DIR_LEFT;
         bar_q   <= BAR_FILL;
         adv_q   <= 1'b0;
         mode_q  <= bus.mode;
      end else begin
         leds_q  <= leds_d;
         count_q <= count_d;
         dir_q   <= dir_d;
         bar_q   <= bar_d;
         adv_q   <= adv_d;
         mode_q  <= bus.mode;
      end
   end

   always_comb begin
      leds_d  = leds_q;
      count_d = count_q;
      dir_d   = dir_q;
      bar_d   = bar_q;
      adv_d   = 1'b0;
      shifted = '0;
      // A comparison with >= lets a lowered period take effect on the next clock.
      tick    = ~bus.pause & (count_q >= bus.period);
      ev      = tick | (bus.pause & bus.step);

      if (bus.mode != mode_q) begin
         leds_d  = WIDTH'(1);
         count_d = '0;
         dir_d   = DIR_LEFT;
         bar_d   = BAR_FILL;
      end else begin
         if (!bus.pause)
            count_d = tick ? '0 : count_q + CNT_W'(1);
         if (ev) begin
            adv_d = 1'b1;
            case (mode_q)
               2'b00: leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
               2'b01: leds_d = {leds_q[0], leds_q[WIDTH-1:1]};
               2'b10: begin
                  // Turn around on reaching an end, so each end LED is lit only once per sweep.
                  if (dir_q == DIR_LEFT) begin
                     shifted = leds_q << 1;
                     if (shifted[WIDTH-1]) dir_d = DIR_RIGHT;
                  end else begin
                     shifted = leds_q >> 1;
                     if (shifted[0]) dir_d = DIR_LEFT;
                  end
                  leds_d = shifted;
               end
               default: begin
                  if (bar_q == BAR_FILL) begin
                     shifted = {leds_q[WIDTH-2:0], 1'b1};
                     if (&shifted) bar_d = BAR_DRAIN;
                  end else begin
                     shifted = {leds_q[WIDTH-2:0], 1'b0};
                     if (shifted == '0) bar_d = BAR_FILL;
                  end
                  leds_d = shifted;
               end
            endcase
         end
      end
   end

   assign bus.leds = leds_q;
   assign bus.adv  = adv_q;

endmodule
